// File: rtl/mux_add_accum_pkg.sv
// rtl/mux_add_accum_pkg.sv - shared opcode type for the operand-select accumulator
package mux_add_accum_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

endpackage

// File: rtl/mux_add_accum_operand_sel_reg.sv
// rtl/mux_add_accum_operand_sel_reg.sv - stage 1: channel mux and operand/opcode register
module operand_sel_reg
    import mux_add_accum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    localparam int SEL_W = $clog2(NCH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    input  op_t                  op_i,
    input  logic [SEL_W-1:0]     sel_i,
    input  logic [NCH*WIDTH-1:0] ch_data_i,
    output logic                 s1_valid_o,
    output op_t                  s1_op_o,
    output logic [WIDTH-1:0]     s1_operand_o
);

    logic             valid_q;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH-1:0] mux_out;

    // Select codes past the last channel fall through to zero.
    always_comb begin
        mux_out = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_i == SEL_W'(i)) begin
                mux_out = ch_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        op_d      = op_q;
        operand_d = operand_q;
        if (in_valid_i) begin
            op_d      = op_i;
            operand_d = mux_out;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            op_q      <= OP_LOAD;
            operand_q <= '0;
        end else begin
            valid_q   <= in_valid_i;
            op_q      <= op_d;
            operand_q <= operand_d;
        end
    end

    assign s1_valid_o   = valid_q;
    assign s1_op_o      = op_q;
    assign s1_operand_o = operand_q;

endmodule

// File: rtl/mux_add_accum.sv
// rtl/mux_add_accum.sv - operand-select add/sub accumulator with sticky overflow and transaction count
module mux_add_accum
    import mux_add_accum_pkg::*;
#(
    parameter int   WIDTH = 8,
    parameter int   NCH   = 4,
    parameter bit   SAT   = 1'b1,
    parameter int   CNT_W = 8,
    localparam int  SEL_W = $clog2(NCH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    input  op_t                  op_i,
    input  logic [SEL_W-1:0]     sel_i,
    input  logic [NCH*WIDTH-1:0] ch_data_i,
    input  logic                 ovf_clr_i,
    output logic [WIDTH-1:0]     res_o,
    output logic                 res_valid_o,
    output logic                 ovf_o,
    output logic [CNT_W-1:0]     count_o
);

    logic             s1_valid;
    op_t              s1_op;
    logic [WIDTH-1:0] s1_operand;

    operand_sel_reg #(
        .WIDTH (WIDTH),
        .NCH   (NCH)
    ) u_operand_sel_reg (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid_i),
        .op_i         (op_i),
        .sel_i        (sel_i),
        .ch_data_i    (ch_data_i),
        .s1_valid_o   (s1_valid),
        .s1_op_o      (s1_op),
        .s1_operand_o (s1_operand)
    );

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             res_valid_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // Extra top bit carries the add carry-out / subtract borrow.
    assign sum  = {1'b0, acc_q} + {1'b0, s1_operand};
    assign diff = {1'b0, acc_q} - {1'b0, s1_operand};

    always_comb begin
        acc_d   = acc_q;
        ovf_d   = ovf_q & ~ovf_clr_i;
        count_d = count_q;
        if (s1_valid) begin
            count_d = count_q + CNT_W'(1);
            unique case (s1_op)
                OP_LOAD: acc_d = s1_operand;
                OP_ADD: begin
                    acc_d = sum[WIDTH-1:0];
                    if (sum[WIDTH]) begin
                        ovf_d = 1'b1;
                        if (SAT) acc_d = '1;
                    end
                end
                OP_SUB: begin
                    acc_d = diff[WIDTH-1:0];
                    if (diff[WIDTH]) begin
                        ovf_d = 1'b1;
                        if (SAT) acc_d = '0;
                    end
                end
                OP_CLEAR: begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end
                default: acc_d = acc_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            res_valid_q <= s1_valid;
            count_q     <= count_d;
        end
    end

    assign res_o       = acc_q;
    assign res_valid_o = res_valid_q;
    assign ovf_o       = ovf_q;
    assign count_o     = count_q;

endmodule

// File: doc/mux_add_accum.md
# mux_add_accum

Parametrised operand-select, add/subtract accumulator with registered pipeline. It selects one of NCH channel operands and combines it with a running accumulator using a per-transaction opcode: load, add, subtract or clear. Overflow is handled as either saturating or wrap-around, and is reported on a sticky flag. It generalises the 4-bit mux → adder → register datapath in width, channel count and operation set, and sits on the arithmetic datapath feeding downstream registers and displays.

## Interface
- WIDTH, 8: operand/accumulator width in bits, ≥ 2
- NCH, 4: number of selectable operand channels, ≥ 2
- SAT, 1: 1 = saturating arithmetic, 0 = wrap-around
- CNT_W, 8: width of the transaction counter
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- IN_VALID  in  1  transaction strobe, sampled each rising edge
- OP  in  2  opcode: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
- SEL  in  $clog2(NCH)  channel select
- CH_DATA  in  NCH*WIDTH  flattened channels; channel i = bits [i*WIDTH +: WIDTH]
- OVF_CLR  in  1  clears sticky OVF
- RES  out  WIDTH  accumulator value
- RES_VALID  out  1  one-cycle pulse: RES just updated
- OVF  out  1  sticky overflow/underflow flag
- COUNT  out  CNT_W  completed transactions since reset

## Operation
- Stage 1 is the operand register. On an edge with IN_VALID=1 it captures:
  - s1_op ← OP
  - s1_operand ← CH_DATA channel SEL; SEL ≥ NCH selects 0
  - s1_valid ← 1
- On an edge with IN_VALID=0, s1_valid ← 0 and s1_op/s1_operand hold.
- Stage 2 is the accumulator. On an edge with s1_valid=1:
  - LOAD: acc ← operand; OVF unchanged.
  - ADD: sum is WIDTH+1 bits unsigned. On carry, acc ← all-ones if SAT=1, else low WIDTH bits; OVF ← 1.
  - SUB: unsigned acc − operand. On borrow, acc ← 0 if SAT=1, else low WIDTH bits (two's-complement wrap); OVF ← 1.
  - CLEAR: acc ← 0 and OVF ← 0; operand ignored.
  - COUNT ← COUNT+1, wrapping at 2^CNT_W.
- RES_VALID ← s1_valid every edge.
- RES is driven directly from acc.
- OVF_CLR=1 clears OVF on the next edge. If it coincides with a new overflow event in stage 2, set wins (OVF=1). If it coincides with CLEAR, OVF=0.
- Stage 2 reads only its own register, so back-to-back transactions have no hazard. Throughput is one transaction per cycle.
- There is no backpressure; IN_VALID is never refused.

## Timing
- Reset values: RES=0, RES_VALID=0, OVF=0, COUNT=0, s1_valid=0, s1_op=LOAD, s1_operand=0.
- RESET forces all state to these values immediately, independent of CLK.
- RESET asserted mid-operation discards the stage-1 contents. No update occurs after release.
- Latency: a transaction sampled at edge k updates RES at edge k+1; RES_VALID is high for the cycle following edge k+1.
- IN_VALID gaps produce no RES change, no RES_VALID pulse and no COUNT change.
- CH_DATA, SEL and OP need to be stable only around the sampling edge.

## Structure
- Package mux_add_accum_pkg holds op_t, a 2-bit enum with OP_LOAD/OP_ADD/OP_SUB/OP_CLEAR.
- Sub-module operand_sel_reg implements stage 1: the NCH-way mux, the out-of-range zeroing and the stage-1 registers, with the same CLK/RESET.
- The top level holds the accumulator, the OVF logic and COUNT.

## Test plan
Default build is WIDTH=8, NCH=4, SAT=1 unless noted.
- Reset: RESET=1 with random inputs → RES=0x00, RES_VALID=0, OVF=0, COUNT=0 immediately, before any clock edge.
- Back-to-back: LOAD ch1=0x10, then ADD ch2=0x05 on consecutive cycles.
  - RES=0x10 then 0x15 on successive edges.
  - RES_VALID high for two consecutive cycles.
  - COUNT=2.
- Add overflow: LOAD 0xF0, then ADD 0x20.
  - SAT=1 → RES=0xFF, OVF=1.
  - SAT=0 build → RES=0x10, OVF=1.
- Sub underflow: LOAD 0x03, then SUB 0x05.
  - SAT=1 → RES=0x00, OVF=1; SAT=0 build → RES=0xFE.
  - OVF_CLR pulse alone → OVF=0.
  - OVF_CLR in the same cycle as an overflowing ADD → OVF=1.
- Select and gaps (NCH=3 build): SEL=3 with ADD onto 0x22 → RES stays 0x22, COUNT+1. IN_VALID low for 3 cycles → no RES_VALID pulse, COUNT unchanged.
- Reset mid-operation: assert RESET while stage 1 holds ADD 0x07 on acc=0x40, then release → RES=0x00, no RES_VALID pulse, COUNT=0.
